jimmy_core: RTL and testbench
=============================

// Module: jimmy_core
// PURPOSE
//  8-bit accumulator CPU core ("jimmy"): fetches 2-byte instructions from a program ROM,
//  reads/writes a 256-byte data RAM, exchanges data over four 8-bit in/out ports.
//  One instance per core in the multicore system; program_memory/data_memory sit outside.
// PARAMETERS
//  RESET_PC  8'h00  program-counter value loaded on reset
// PORTS
//  clk            in     1  single clock; all state updates on rising edge
//  reset          in     1  synchronous, active-high; clears all state
//  code_data_bus  in     8  ROM byte at code_addr_bus (combinational read)
//  code_addr_bus  out    8  ROM fetch address (= PC or PC+1)
//  mem_data_bus   inout  8  RAM data; core drives only while mem_we=1, else high-Z
//  mem_addr_bus   out    8  RAM address (instruction operand)
//  mem_we         out    1  RAM write enable; RAM writes mem_data_bus on rising edge
//  in_port_0..3   in     8  input ports
//  out_port_0..3  out    8  registered output ports
//  out_strobe     out    4  bit p pulses high 1 cycle when out_port_p is written
// BEHAVIOUR
//  - Reset (sync, high): PC=RESET_PC, A=0, Z=0, C=0, IR=0, state=F0, out_port_*=0,
//    out_strobe=0, mem_we=0, mem_addr_bus=0, mem_data_bus high-Z.
//  - Instruction = opcode byte (bits[7:4] op, [3:0] ignored) at PC, operand byte at PC+1.
//  - FSM: F0 (latch opcode, addr=PC) -> F1 (latch operand, addr=PC+1) -> EX -> F0;
//    HALT state entered by op F, left only by reset. 3 cycles/instruction. PC += 2 in EX
//    unless a jump is taken (PC=operand). PC wraps 8'hFF->8'h00 (8-bit arithmetic).
//  - Opcodes (k = operand, M = mem[k], p = k[1:0]):
//    0 NOP | 1 LDI A=k | 2 LD A=M | 3 ST M=A | 4 ADD A=A+M | 5 SUB A=A-M
//    6 AND A&=M | 7 OR A|=M | 8 XOR A^=M | 9 ADDI A=A+k | A JMP k | B JZ k if Z
//    C JC k if C | D IN A=in_port_p | E OUT out_port_p=A | F HALT
//  - Flags: Z=(new A==0) after 1,2,4-9,D; C=carry-out for ADD/ADDI, borrow (A<M) for SUB,
//    cleared by AND/OR/XOR; unchanged otherwise. Flags never change on ST/JMP/JZ/JC/OUT/NOP.
//  - Memory: in EX mem_addr_bus=k; reads combinational same cycle. ST: mem_we=1 and
//    mem_data_bus=A for exactly the EX cycle; all other cycles mem_we=0, bus released.
//  - OUT: out_port_p registered at end of EX; out_strobe[p]=1 the following cycle only,
//    other bits 0. Back-to-back OUTs to same port give strobe 0->1 pulses 3 cycles apart.
//  - Reset mid-instruction aborts it: no partial write, strobe cleared same edge.
//  - IN samples in_port_p in EX cycle; no synchronisation required (ports are synchronous).
// STRUCTURE
//  - Package jimmy_pkg: opcode enum (4-bit), FSM state enum {F0,F1,EX,HALT}, flag struct.
//  - Sub-module jimmy_alu: combinational, inputs op, A, operand/M; outputs result, Z, C.
//  - Top: FSM, PC/IR/A/flag registers, bus muxing, port registers, tri-state driver.
// TESTING
//  1. Reset held 10 cycles -> code_addr_bus=00, out_strobe=0, out_port_2=0, mem_we=0.
//  2. ROM: LDI 5; ADDI 7; OUT 2; HALT -> out_port_2=12, out_strobe=4'b0100 one cycle
//     at cycle 9 after reset release, then PC frozen.
//  3. LDI 8'hF0; ST 10; LDI 8'h20; ADD 10; JC 20 -> RAM[10]=F0 (mem_we one cycle), A=10,
//     C=1, PC=20.
//  4. IN 3 with in_port_3=255; ADDI 1; JZ 30 -> A=0, Z=1, jump taken to 30.
//  5. Count loop: LDI 0; L: ADDI 1; OUT 2; SUB (RAM[40]=5); JZ done; LD..JMP L ->
//     five out_strobe[2] pulses, final out_port_2=5.
//  6. Assert reset during EX of ST -> RAM unchanged, core restarts at RESET_PC.

Source files
------------

// File: rtl/jimmy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jimmy_pkg
//  Description : Shared types for the jimmy 8-bit accumulator core.
//  Revision    : 1.0 - initial release
// ============================================================================
package jimmy_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_ADDI = 4'h9,
        OP_JMP  = 4'hA,
        OP_JZ   = 4'hB,
        OP_JC   = 4'hC,
        OP_IN   = 4'hD,
        OP_OUT  = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_F0   = 2'd0,
        ST_F1   = 2'd1,
        ST_EX   = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    typedef struct packed {
        logic z;
        logic c;
    } flags_t;

    // Opcodes whose result lands in A; Z tracks exactly this set.
    function automatic logic writes_acc(opcode_e op);
        case (op)
            OP_LDI, OP_LD, OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_ADDI, OP_IN: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic writes_carry(opcode_e op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/jimmy_if.sv
`default_nettype none
// ============================================================================
//  Module      : jimmy_if
//  Description : Code-fetch, RAM control and I/O port bundle of one jimmy core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jimmy_if;
    import jimmy_pkg::*;

    logic [DATA_W-1:0] code_data_bus;
    logic [DATA_W-1:0] code_addr_bus;
    logic [DATA_W-1:0] mem_addr_bus;
    logic              mem_we;
    logic [DATA_W-1:0] in_port_0;
    logic [DATA_W-1:0] in_port_1;
    logic [DATA_W-1:0] in_port_2;
    logic [DATA_W-1:0] in_port_3;
    logic [DATA_W-1:0] out_port_0;
    logic [DATA_W-1:0] out_port_1;
    logic [DATA_W-1:0] out_port_2;
    logic [DATA_W-1:0] out_port_3;
    logic [3:0]        out_strobe;

    modport master (
        input  code_data_bus,
        input  in_port_0, in_port_1, in_port_2, in_port_3,
        output code_addr_bus, mem_addr_bus, mem_we,
        output out_port_0, out_port_1, out_port_2, out_port_3,
        output out_strobe
    );

    modport slave (
        output code_data_bus,
        output in_port_0, in_port_1, in_port_2, in_port_3,
        input  code_addr_bus, mem_addr_bus, mem_we,
        input  out_port_0, out_port_1, out_port_2, out_port_3,
        input  out_strobe
    );

endinterface
`default_nettype wire

// File: rtl/jimmy_alu.sv
`default_nettype none
// ============================================================================
//  Module      : jimmy_alu
//  Description : Combinational ALU; b_i is the immediate, RAM word or input port.
//  Revision    : 1.0 - initial release
// ============================================================================
module jimmy_alu
    import jimmy_pkg::*;
(
    input  opcode_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              z_o,
    output logic              c_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        // Top bit of the widened difference is the borrow (a < b).
        diff     = {1'b0, a_i} - {1'b0, b_i};
        result_o = a_i;
        c_o      = 1'b0;
        case (op_i)
            OP_ADD, OP_ADDI: begin
                result_o = sum[DATA_W-1:0];
                c_o      = sum[DATA_W];
            end
            OP_SUB: begin
                result_o = diff[DATA_W-1:0];
                c_o      = diff[DATA_W];
            end
            OP_AND:               result_o = a_i & b_i;
            OP_OR:                result_o = a_i | b_i;
            OP_XOR:               result_o = a_i ^ b_i;
            OP_LDI, OP_LD, OP_IN: result_o = b_i;
            default:              result_o = a_i;
        endcase
        z_o = (result_o == '0);
    end

endmodule
`default_nettype wire

// File: rtl/jimmy_core.sv
`default_nettype none
// ============================================================================
//  Module      : jimmy_core
//  Description : 8-bit accumulator CPU, 3-cycle fetch/fetch/execute sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module jimmy_core
    import jimmy_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    jimmy_if.master     bus,
    inout  wire  [7:0]  mem_data_bus
);

    state_e                 state_q;
    opcode_e                ir_q;
    flags_t                 flags_q, flags_d;
    logic [DATA_W-1:0]      pc_q, pc_d;
    logic [DATA_W-1:0]      a_q, a_d;
    logic [DATA_W-1:0]      operand_q;
    logic [3:0][DATA_W-1:0] out_port_q;
    logic [3:0]             strobe_q;

    logic [1:0]        port_sel;
    logic [DATA_W-1:0] in_sel;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_z;
    logic              alu_c;
    logic              jump_taken;
    logic              ex_store;

    always_comb begin
        port_sel = operand_q[1:0];
        case (port_sel)
            2'd0:    in_sel = bus.in_port_0;
            2'd1:    in_sel = bus.in_port_1;
            2'd2:    in_sel = bus.in_port_2;
            default: in_sel = bus.in_port_3;
        endcase
        case (ir_q)
            OP_LDI, OP_ADDI: alu_b = operand_q;
            OP_IN:           alu_b = in_sel;
            default:         alu_b = mem_data_bus;
        endcase
    end

    jimmy_alu u_alu (
        .op_i     (ir_q),
        .a_i      (a_q),
        .b_i      (alu_b),
        .result_o (alu_res),
        .z_o      (alu_z),
        .c_o      (alu_c)
    );

    always_comb begin
        a_d     = writes_acc(ir_q) ? alu_res : a_q;
        flags_d = flags_q;
        if (writes_acc(ir_q))   flags_d.z = alu_z;
        if (writes_carry(ir_q)) flags_d.c = alu_c;
        jump_taken = (ir_q == OP_JMP)
                   || ((ir_q == OP_JZ) && flags_q.z)
                   || ((ir_q == OP_JC) && flags_q.c);
        pc_d = jump_taken ? operand_q : pc_q + 8'd2;
    end

    // Gating with reset keeps a reset that lands on a store from writing RAM.
    assign ex_store = (state_q == ST_EX) && (ir_q == OP_ST) && !reset;

    assign mem_data_bus      = ex_store ? a_q : 8'hzz;
    assign bus.mem_we        = ex_store;
    assign bus.mem_addr_bus  = operand_q;
    assign bus.code_addr_bus = (state_q == ST_F1) ? pc_q + 8'd1 : pc_q;
    assign bus.out_port_0    = out_port_q[0];
    assign bus.out_port_1    = out_port_q[1];
    assign bus.out_port_2    = out_port_q[2];
    assign bus.out_port_3    = out_port_q[3];
    assign bus.out_strobe    = strobe_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_F0;
            pc_q       <= RESET_PC;
            a_q        <= '0;
            flags_q    <= '0;
            ir_q       <= OP_NOP;
            operand_q  <= '0;
            out_port_q <= '0;
            strobe_q   <= '0;
        end else begin
            strobe_q <= '0;
            case (state_q)
                ST_F0: begin
                    ir_q    <= opcode_e'(bus.code_data_bus[7:4]);
                    state_q <= ST_F1;
                end
                ST_F1: begin
                    operand_q <= bus.code_data_bus;
                    state_q   <= ST_EX;
                end
                ST_EX: begin
                    a_q     <= a_d;
                    flags_q <= flags_d;
                    pc_q    <= pc_d;
                    if (ir_q == OP_OUT) begin
                        out_port_q[port_sel] <= a_q;
                        strobe_q[port_sel]   <= 1'b1;
                    end
                    state_q <= (ir_q == OP_HALT) ? ST_HALT : ST_F0;
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jimmy_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jimmy_core
//  Description : Directed-program bench for jimmy_core with ROM/RAM models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jimmy_core;

    logic       clk;
    logic       reset;
    logic [7:0] rom [256];
    logic [7:0] ram [256];
    wire  [7:0] mem_data_bus;
    int         n_vec;
    int         n_err;
    int         we_cnt;
    int         strobe_cnt [4];

    jimmy_if ifc ();

    jimmy_core #(.RESET_PC(8'h00)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (ifc),
        .mem_data_bus (mem_data_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ifc.code_data_bus = rom[ifc.code_addr_bus];
    assign mem_data_bus      = ifc.mem_we ? 8'hzz : ram[ifc.mem_addr_bus];

    always @(posedge clk) begin
        if (ifc.mem_we) begin
            ram[ifc.mem_addr_bus] = mem_data_bus;
            we_cnt++;
        end
        for (int b = 0; b < 4; b++) strobe_cnt[b] += int'(ifc.out_strobe[b]);
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic put(input logic [7:0] addr, input logic [7:0] op, input logic [7:0] k);
        rom[addr]        = op;
        rom[addr + 8'd1] = k;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_rom();
        @(negedge clk) reset = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++; if (ifc.code_addr_bus !== 8'h00) begin n_err++; $display("FAIL rst_pc: got %h want 00", ifc.code_addr_bus); end
        n_vec++; if (ifc.out_strobe !== 4'b0000) begin n_err++; $display("FAIL rst_strobe: got %b want 0000", ifc.out_strobe); end
        n_vec++; if (ifc.out_port_2 !== 8'h00) begin n_err++; $display("FAIL rst_port2: got %h want 00", ifc.out_port_2); end
        n_vec++; if (ifc.mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", ifc.mem_we); end
        reset = 1'b0;
    endtask

    task automatic test_addi_out();
        clear_rom();
        put(8'h00, 8'h10, 8'h05);
        put(8'h02, 8'h90, 8'h07);
        put(8'h04, 8'hE0, 8'h02);
        put(8'h06, 8'hF0, 8'h00);
        do_reset();
        run(8);
        n_vec++; if (ifc.out_strobe !== 4'b0000) begin n_err++; $display("FAIL out_early: got %b want 0000", ifc.out_strobe); end
        run(1);
        n_vec++; if (ifc.out_strobe !== 4'b0100) begin n_err++; $display("FAIL out_strobe: got %b want 0100", ifc.out_strobe); end
        n_vec++; if (ifc.out_port_2 !== 8'd12) begin n_err++; $display("FAIL out_port2: got %h want 0c", ifc.out_port_2); end
        run(1);
        n_vec++; if (ifc.out_strobe !== 4'b0000) begin n_err++; $display("FAIL out_late: got %b want 0000", ifc.out_strobe); end
        run(5);
        n_vec++; if (ifc.code_addr_bus !== 8'h08) begin n_err++; $display("FAIL halt_pc: got %h want 08", ifc.code_addr_bus); end
        run(10);
        n_vec++; if (ifc.code_addr_bus !== 8'h08) begin n_err++; $display("FAIL halt_frozen: got %h want 08", ifc.code_addr_bus); end
    endtask

    task automatic test_back_to_back();
        bit exp_s [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        clear_rom();
        put(8'h00, 8'h10, 8'h03);
        put(8'h02, 8'hE0, 8'h01);
        put(8'h04, 8'hE0, 8'h01);
        put(8'h06, 8'hF0, 8'h00);
        do_reset();
        run(5);
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (ifc.out_strobe[1] !== exp_s[i]) begin
                n_err++; $display("FAIL b2b_strobe[%0d]: got %b want %b", i, ifc.out_strobe[1], exp_s[i]);
            end
            run(1);
        end
        n_vec++; if (ifc.out_port_1 !== 8'h03) begin n_err++; $display("FAIL b2b_port1: got %h want 03", ifc.out_port_1); end
    endtask

    task automatic test_store_add_jc();
        int w0, s0;
        clear_rom();
        ram[8'h10] = 8'h00;
        put(8'h00, 8'h10, 8'hF0);
        put(8'h02, 8'h30, 8'h10);
        put(8'h04, 8'h10, 8'h20);
        put(8'h06, 8'h40, 8'h10);
        put(8'h08, 8'hC0, 8'h20);
        put(8'h0A, 8'hE0, 8'h01);
        put(8'h0C, 8'hF0, 8'h00);
        put(8'h20, 8'hE0, 8'h00);
        put(8'h22, 8'hF0, 8'h00);
        do_reset();
        w0 = we_cnt; s0 = strobe_cnt[0];
        run(25);
        n_vec++; if (ram[8'h10] !== 8'hF0) begin n_err++; $display("FAIL st_ram: got %h want f0", ram[8'h10]); end
        n_vec++; if (we_cnt - w0 !== 1) begin n_err++; $display("FAIL st_we_cycles: got %0d want 1", we_cnt - w0); end
        n_vec++; if (ifc.out_port_0 !== 8'h10) begin n_err++; $display("FAIL add_a: got %h want 10", ifc.out_port_0); end
        n_vec++; if (strobe_cnt[0] - s0 !== 1) begin n_err++; $display("FAIL jc_taken: got %0d want 1", strobe_cnt[0] - s0); end
        n_vec++; if (ifc.out_port_1 !== 8'h00) begin n_err++; $display("FAIL jc_fallthru: got %h want 00", ifc.out_port_1); end
        n_vec++; if (ifc.code_addr_bus !== 8'h24) begin n_err++; $display("FAIL jc_pc: got %h want 24", ifc.code_addr_bus); end
    endtask

    task automatic test_in_jz();
        int s3, s2;
        clear_rom();
        ifc.in_port_0 = 8'h11; ifc.in_port_1 = 8'h22;
        ifc.in_port_2 = 8'h44; ifc.in_port_3 = 8'hFF;
        put(8'h00, 8'hD0, 8'h03);
        put(8'h02, 8'h90, 8'h01);
        put(8'h04, 8'hB0, 8'h30);
        put(8'h06, 8'h10, 8'hEE);
        put(8'h08, 8'hE0, 8'h02);
        put(8'h0A, 8'hF0, 8'h00);
        put(8'h30, 8'hE0, 8'h03);
        put(8'h32, 8'h90, 8'h33);
        put(8'h34, 8'hE0, 8'h01);
        put(8'h36, 8'hF0, 8'h00);
        do_reset();
        s3 = strobe_cnt[3]; s2 = strobe_cnt[2];
        run(25);
        n_vec++; if (strobe_cnt[3] - s3 !== 1) begin n_err++; $display("FAIL jz_taken: got %0d want 1", strobe_cnt[3] - s3); end
        n_vec++; if (ifc.out_port_3 !== 8'h00) begin n_err++; $display("FAIL in_wrap_a: got %h want 00", ifc.out_port_3); end
        n_vec++; if (ifc.out_port_1 !== 8'h33) begin n_err++; $display("FAIL after_jz: got %h want 33", ifc.out_port_1); end
        n_vec++; if (strobe_cnt[2] - s2 !== 0) begin n_err++; $display("FAIL jz_fallthru: got %0d want 0", strobe_cnt[2] - s2); end
        n_vec++; if (ifc.code_addr_bus !== 8'h38) begin n_err++; $display("FAIL jz_pc: got %h want 38", ifc.code_addr_bus); end
    endtask

    task automatic test_logic();
        clear_rom();
        ram[8'h50] = 8'h5A; ram[8'h51] = 8'h81;
        put(8'h00, 8'h10, 8'h3C);
        put(8'h02, 8'h60, 8'h50);
        put(8'h04, 8'hE0, 8'h00);
        put(8'h06, 8'h80, 8'h50);
        put(8'h08, 8'hE0, 8'h01);
        put(8'h0A, 8'h70, 8'h51);
        put(8'h0C, 8'hE0, 8'h02);
        put(8'h0E, 8'h50, 8'h50);
        put(8'h10, 8'hC0, 8'h30);
        put(8'h12, 8'hE0, 8'h03);
        put(8'h14, 8'hF0, 8'h00);
        put(8'h30, 8'h10, 8'hFF);
        put(8'h32, 8'hE0, 8'h03);
        put(8'h34, 8'hF0, 8'h00);
        do_reset();
        run(40);
        n_vec++; if (ifc.out_port_0 !== 8'h18) begin n_err++; $display("FAIL and: got %h want 18", ifc.out_port_0); end
        n_vec++; if (ifc.out_port_1 !== 8'h42) begin n_err++; $display("FAIL xor: got %h want 42", ifc.out_port_1); end
        n_vec++; if (ifc.out_port_2 !== 8'hC3) begin n_err++; $display("FAIL or: got %h want c3", ifc.out_port_2); end
        n_vec++; if (ifc.out_port_3 !== 8'h69) begin n_err++; $display("FAIL sub_noborrow: got %h want 69", ifc.out_port_3); end
        n_vec++; if (ifc.code_addr_bus !== 8'h16) begin n_err++; $display("FAIL logic_pc: got %h want 16", ifc.code_addr_bus); end
    endtask

    task automatic test_count_loop();
        int s2;
        clear_rom();
        ram[8'h40] = 8'h05; ram[8'h41] = 8'h00;
        put(8'h00, 8'h10, 8'h00);
        put(8'h02, 8'h90, 8'h01);
        put(8'h04, 8'hE0, 8'h02);
        put(8'h06, 8'h30, 8'h41);
        put(8'h08, 8'h50, 8'h40);
        put(8'h0A, 8'hB0, 8'h10);
        put(8'h0C, 8'h20, 8'h41);
        put(8'h0E, 8'hA0, 8'h02);
        put(8'h10, 8'hF0, 8'h00);
        do_reset();
        s2 = strobe_cnt[2];
        run(120);
        n_vec++; if (strobe_cnt[2] - s2 !== 5) begin n_err++; $display("FAIL loop_pulses: got %0d want 5", strobe_cnt[2] - s2); end
        n_vec++; if (ifc.out_port_2 !== 8'h05) begin n_err++; $display("FAIL loop_port2: got %h want 05", ifc.out_port_2); end
        n_vec++; if (ram[8'h41] !== 8'h05) begin n_err++; $display("FAIL loop_ram: got %h want 05", ram[8'h41]); end
        n_vec++; if (ifc.code_addr_bus !== 8'h12) begin n_err++; $display("FAIL loop_pc: got %h want 12", ifc.code_addr_bus); end
    endtask

    task automatic test_reset_during_store();
        clear_rom();
        ram[8'h10] = 8'hAA;
        put(8'h00, 8'h10, 8'h55);
        put(8'h02, 8'h30, 8'h10);
        put(8'h04, 8'hF0, 8'h00);
        do_reset();
        run(5);
        n_vec++; if (ifc.mem_we !== 1'b1) begin n_err++; $display("FAIL st_we_ex: got %b want 1", ifc.mem_we); end
        @(negedge clk) reset = 1'b1;
        #1;
        n_vec++; if (ifc.mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we_gate: got %b want 0", ifc.mem_we); end
        run(1);
        n_vec++; if (ram[8'h10] !== 8'hAA) begin n_err++; $display("FAIL rst_no_write: got %h want aa", ram[8'h10]); end
        n_vec++; if (ifc.code_addr_bus !== 8'h00) begin n_err++; $display("FAIL rst_restart_pc: got %h want 00", ifc.code_addr_bus); end
        @(negedge clk) reset = 1'b0;
        run(12);
        n_vec++; if (ram[8'h10] !== 8'h55) begin n_err++; $display("FAIL rerun_store: got %h want 55", ram[8'h10]); end
    endtask

    initial begin
        n_vec = 0; n_err = 0; we_cnt = 0;
        for (int b = 0; b < 4; b++) strobe_cnt[b] = 0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        reset = 1'b1;
        ifc.in_port_0 = 8'h00; ifc.in_port_1 = 8'h00;
        ifc.in_port_2 = 8'h00; ifc.in_port_3 = 8'h00;
        test_reset();
        test_addi_out();
        test_back_to_back();
        test_store_add_jc();
        test_in_jz();
        test_logic();
        test_count_loop();
        test_reset_during_store();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
